// File: rtl/escalonador_proc_pkg.sv
// Shared definitions for the process scheduler and the PC manager it feeds.
package escalonador_proc_pkg;
    localparam int unsigned ID_W = 2;

    typedef enum logic [1:0] {
        SO      = 2'd0,
        USUARIO = 2'd1,
        TROCA   = 2'd2
    } estado_t;

    localparam logic [ID_W-1:0] ID_SO = '0;

    // Fixed entry points in the PC manager: halt target and context-switch routine
    localparam logic [31:0] PC_HALT  = 32'd67;
    localparam logic [31:0] PC_TROCA = 32'd68;
endpackage

// File: rtl/escalonador_proc_seletor_rr.sv
// Combinational round-robin picker: first ready user slot after ultimo_id, wrapping past slot 0.
module seletor_rr
    import escalonador_proc_pkg::*;
#(
    parameter int unsigned NPROC = 4
) (
    input  logic [NPROC-1:0] proc_prontos,
    input  logic [ID_W-1:0]  ultimo_id,
    output logic [ID_W-1:0]  prox_id
);
    localparam int unsigned IDX_W = $clog2(NPROC);

    int unsigned base;
    int unsigned cand;
    logic        achou;
    logic        unusedBit0;

    assign unusedBit0 = proc_prontos[0];

    // Walk the user slots 1..NPROC-1 as a ring; ultimo_id=0 starts the walk at slot 1
    always_comb begin
        prox_id = ID_SO;
        achou   = 1'b0;
        cand    = 0;
        base    = (ultimo_id == ID_SO) ? NPROC - 1 : 32'(ultimo_id);
        for (int unsigned off = 1; off < NPROC; off++) begin
            cand = ((base - 1 + off) % (NPROC - 1)) + 1;
            if (!achou && proc_prontos[IDX_W'(cand)]) begin
                prox_id = ID_W'(cand);
                achou   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/escalonador_proc.sv
// Round-robin scheduler: quantum timer, resume-PC table and dispatch control for the PC manager.
module escalonador_proc
    import escalonador_proc_pkg::*;
#(
    parameter int unsigned QUANTUM = 64,
    parameter int unsigned NPROC   = 4,
    parameter int unsigned PC_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HALT,
    input  logic [PC_W-1:0]   novoPC,
    input  logic              ativa_proc,
    input  logic [ID_W-1:0]   novo_id,
    input  logic              carrega_proc,
    input  logic [ID_W-1:0]   carga_id,
    input  logic [PC_W-1:0]   carga_pc,
    output logic [ID_W-1:0]   id_proc,
    output logic              troca_ctx,
    output logic [PC_W-1:0]   pc_retorno,
    output logic [ID_W-1:0]   prox_id,
    output logic [NPROC-1:0]  proc_prontos,
    output logic              erro_despacho
);
    localparam int unsigned CNT_W = $clog2(QUANTUM);

    estado_t          estado, estadoNx;
    logic [CNT_W-1:0] cnt, cntNx;
    logic [ID_W-1:0]  ultimoId, ultimoNx, idNx;
    logic             trocaNx, erroNx;
    logic [NPROC-1:0] pronto, prontoNx, prontoCarga;
    logic [PC_W-1:0]  tabela [NPROC];
    logic             wrEn;
    logic [ID_W-1:0]  wrIdx;
    logic [PC_W-1:0]  wrPc;

    always_comb begin
        estadoNx    = estado;
        idNx        = id_proc;
        trocaNx     = 1'b0;
        erroNx      = 1'b0;
        cntNx       = cnt;
        ultimoNx    = ultimoId;
        prontoNx    = pronto;
        prontoCarga = pronto;
        wrEn        = 1'b0;
        wrIdx       = carga_id;
        wrPc        = carga_pc;
        unique case (estado)
            SO: begin
                if (!HALT) begin
                    // Load is applied before the dispatch check so a same-slot load+dispatch succeeds
                    if (carrega_proc && carga_id != ID_SO) begin
                        wrEn                  = 1'b1;
                        prontoCarga[carga_id] = 1'b1;
                    end
                    prontoNx = prontoCarga;
                    if (ativa_proc) begin
                        if (novo_id != ID_SO && prontoCarga[novo_id]) begin
                            idNx     = novo_id;
                            ultimoNx = novo_id;
                            cntNx    = '0;
                            estadoNx = USUARIO;
                        end else begin
                            erroNx = 1'b1;
                        end
                    end
                end
            end
            USUARIO: begin
                erroNx = ativa_proc;
                if (HALT) begin
                    prontoNx[id_proc] = 1'b0;
                    idNx              = ID_SO;
                    cntNx             = '0;
                    estadoNx          = SO;
                end else if (cnt == CNT_W'(QUANTUM - 1)) begin
                    trocaNx  = 1'b1;
                    cntNx    = '0;
                    estadoNx = TROCA;
                end else begin
                    cntNx = cnt + 1'b1;
                end
            end
            TROCA: begin
                erroNx = ativa_proc;
                if (HALT) begin
                    prontoNx[id_proc] = 1'b0;
                end else begin
                    wrEn  = 1'b1;
                    wrIdx = id_proc;
                    wrPc  = novoPC;
                end
                idNx     = ID_SO;
                cntNx    = '0;
                estadoNx = SO;
            end
            default: begin
                estadoNx = SO;
                idNx     = ID_SO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= SO;
            id_proc       <= ID_SO;
            troca_ctx     <= 1'b0;
            erro_despacho <= 1'b0;
            cnt           <= '0;
            ultimoId      <= ID_SO;
            pronto        <= '0;
            for (int unsigned i = 0; i < NPROC; i++) tabela[i] <= '0;
        end else begin
            estado        <= estadoNx;
            id_proc       <= idNx;
            troca_ctx     <= trocaNx;
            erro_despacho <= erroNx;
            cnt           <= cntNx;
            ultimoId      <= ultimoNx;
            pronto        <= prontoNx;
            if (wrEn) tabela[wrIdx] <= wrPc;
        end
    end

    assign pc_retorno   = tabela[novo_id];
    assign proc_prontos = pronto;

    seletor_rr #(.NPROC(NPROC)) uSeletor (
        .proc_prontos (pronto),
        .ultimo_id    (ultimoId),
        .prox_id      (prox_id)
    );
endmodule
